// File: rtl/prng_stream_source.sv
// Galois-LFSR word generator with single/burst/continuous run modes, feeding a
// first-word-fall-through FIFO with a valid/ready output stream.
module prng_stream_source #(
    parameter int unsigned LFSR_WIDTH = 8,
    parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS = 8'hB8,
    parameter logic [LFSR_WIDTH-1:0] LFSR_SEED = {{(LFSR_WIDTH-1){1'b0}}, 1'b1},
    parameter int unsigned WORD_WIDTH = 4,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned BURST_WIDTH = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [1:0]                      mode,
    input  logic                            start,
    input  logic                            stop,
    input  logic [BURST_WIDTH-1:0]          burst_len,
    input  logic                            reseed,
    input  logic [LFSR_WIDTH-1:0]           seed_in,
    output logic [WORD_WIDTH-1:0]           data_out,
    output logic                            data_valid,
    input  logic                            data_ready,
    output logic                            busy,
    output logic                            full,
    output logic                            empty,
    output logic [$clog2(FIFO_DEPTH):0]     fill_level,
    output logic [15:0]                     words_generated
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [LFSR_WIDTH-1:0] LFSR_ONE = {{(LFSR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [LFSR_WIDTH-1:0] SEED_RESET = (LFSR_SEED == '0) ? LFSR_ONE : LFSR_SEED;
    localparam logic [BURST_WIDTH-1:0] BURST_ONE = {{(BURST_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state, state_next;

    logic [LFSR_WIDTH-1:0]  lfsr;
    logic [LFSR_WIDTH-1:0]  lfsr_stepped;
    logic [LFSR_WIDTH-1:0]  seed_clean;
    logic [WORD_WIDTH-1:0]  word;

    logic                   continuous;
    logic [BURST_WIDTH-1:0] remaining;
    logic [BURST_WIDTH-1:0] burst_clean;

    logic                   push;
    logic                   pop;
    logic                   do_reseed;
    logic                   do_start;

    logic [WORD_WIDTH-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;

    // Advance WORD_WIDTH Galois steps; word bit i is the bit shifted out on step i.
    always_comb begin
        logic [LFSR_WIDTH-1:0] s;
        s    = lfsr;
        word = '0;
        for (int unsigned i = 0; i < WORD_WIDTH; i++) begin
            word[i] = s[0];
            s = s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
        end
        lfsr_stepped = s;
    end

    assign seed_clean  = (seed_in == '0) ? LFSR_ONE : seed_in;
    assign burst_clean = (burst_len == '0) ? BURST_ONE : burst_len;

    assign empty      = (count == '0);
    assign full       = (count == CNT_W'(FIFO_DEPTH));
    assign fill_level = count;
    assign data_valid = !empty;
    assign data_out   = empty ? '0 : mem[rd_ptr];
    assign pop        = data_valid && data_ready;
    assign busy       = (state != IDLE);

    always_comb begin
        state_next = state;
        push       = 1'b0;
        do_reseed  = 1'b0;
        do_start   = 1'b0;
        case (state)
            IDLE: begin
                if (reseed) begin
                    do_reseed = 1'b1;
                end else if (start) begin
                    do_start   = 1'b1;
                    state_next = GEN;
                end
            end
            GEN: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (full && !pop) begin
                    state_next = HOLD;
                end else begin
                    push = 1'b1;
                    if (!continuous && remaining == BURST_ONE) begin
                        state_next = IDLE;
                    end
                end
            end
            HOLD: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (!full) begin
                    state_next = GEN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr            <= SEED_RESET;
            continuous      <= 1'b0;
            remaining       <= '0;
            words_generated <= '0;
        end else begin
            if (do_reseed) begin
                lfsr <= seed_clean;
            end else if (push) begin
                lfsr <= lfsr_stepped;
            end

            // mode 3 falls through to single-word behaviour
            if (do_start) begin
                continuous      <= (mode == 2'd2);
                remaining       <= (mode == 2'd1) ? burst_clean : BURST_ONE;
                words_generated <= '0;
            end else if (push) begin
                if (!continuous) begin
                    remaining <= remaining - BURST_ONE;
                end
                if (words_generated != 16'hFFFF) begin
                    words_generated <= words_generated + 16'd1;
                end
            end
        end
    end

    // Storage is not reset; the pointers and count alone define valid contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= word;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_prng_stream_source.sv
// Directed bench for prng_stream_source: run modes, back-pressure, reseed,
// stop and mid-run reset, with expected words computed by hand or a tiny model.
module tb_prng_stream_source;

    logic        clk;
    logic        reset;
    logic [1:0]  mode;
    logic        start;
    logic        stop;
    logic [7:0]  burst_len;
    logic        reseed;
    logic [7:0]  seed_in;
    logic [3:0]  data_out;
    logic        data_valid;
    logic        data_ready;
    logic        busy;
    logic        full;
    logic        empty;
    logic [4:0]  fill_level;
    logic [15:0] words_generated;

    int n_cmp;
    int n_err;

    logic [7:0] ref_s;
    logic [3:0] w [1:17];

    prng_stream_source #(
        .LFSR_WIDTH (8),
        .LFSR_TAPS  (8'hB8),
        .LFSR_SEED  (8'h01),
        .WORD_WIDTH (4),
        .FIFO_DEPTH (16),
        .BURST_WIDTH(8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mode           (mode),
        .start          (start),
        .stop           (stop),
        .burst_len      (burst_len),
        .reseed         (reseed),
        .seed_in        (seed_in),
        .data_out       (data_out),
        .data_valid     (data_valid),
        .data_ready     (data_ready),
        .busy           (busy),
        .full           (full),
        .empty          (empty),
        .fill_level     (fill_level),
        .words_generated(words_generated)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [3:0] model_word();
        logic [3:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i] = ref_s[0];
            ref_s = ref_s[0] ? ((ref_s >> 1) ^ 8'hB8) : (ref_s >> 1);
        end
        return r;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        reset = 1'b1; mode = 2'd0; start = 1'b0; stop = 1'b0; burst_len = 8'd0;
        reseed = 1'b0; seed_in = 8'd0; data_ready = 1'b0;
        step(); step();
        chk("rst_empty", empty, 1'b1);
        chk("rst_fill", fill_level, 5'd0);
        chk("rst_valid", data_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_full", full, 1'b0);
        chk("rst_data", data_out, 4'h0);
        chk("rst_wg", words_generated, 16'd0);
        reset = 1'b0;
        step();

        // single word, consumer ready
        mode = 2'd0; start = 1'b1; data_ready = 1'b1;
        step(); start = 1'b0;
        chk("single_busy", busy, 1'b1);
        chk("single_lat_valid", data_valid, 1'b0);
        step();
        chk("single_valid", data_valid, 1'b1);
        chk("single_word", data_out, 4'h1);
        chk("single_busy_low", busy, 1'b0);
        chk("single_wg", words_generated, 16'd1);
        step();
        chk("single_drained", data_valid, 1'b0);
        data_ready = 1'b0;

        // burst of 3 from fresh seed, buffered then drained
        do_reset();
        mode = 2'd1; burst_len = 8'd3; start = 1'b1;
        step(); start = 1'b0;
        chk("burst_busy0", busy, 1'b1);
        step();
        chk("burst_fill1", fill_level, 5'd1);
        step();
        chk("burst_fill2", fill_level, 5'd2);
        chk("burst_busy2", busy, 1'b1);
        step();
        chk("burst_fill3", fill_level, 5'd3);
        chk("burst_busy_low", busy, 1'b0);
        chk("burst_wg", words_generated, 16'd3);
        chk("burst_w0", data_out, 4'h1);
        data_ready = 1'b1;
        step();
        chk("burst_w1", data_out, 4'h7);
        step();
        chk("burst_w2", data_out, 4'h4);
        step();
        chk("burst_empty", empty, 1'b1);
        data_ready = 1'b0;

        // continuous fill to full, HOLD, single pop gives exactly one more push
        ref_s = 8'h5A;
        for (int k = 1; k <= 17; k++) w[k] = model_word();
        chk("model_first", w[1], 4'hA);
        mode = 2'd2; start = 1'b1;
        step(); start = 1'b0;
        for (int k = 0; k < 19; k++) step();
        chk("cont_full", full, 1'b1);
        chk("cont_fill16", fill_level, 5'd16);
        chk("cont_busy", busy, 1'b1);
        chk("cont_wg16", words_generated, 16'd16);
        chk("cont_head", data_out, w[1]);
        data_ready = 1'b1;
        step(); data_ready = 1'b0;
        chk("cont_pop_fill", fill_level, 5'd15);
        step(); step(); step();
        chk("cont_refill", fill_level, 5'd16);
        chk("cont_wg17", words_generated, 16'd17);
        step(); step(); step(); step();
        chk("cont_hold_wg", words_generated, 16'd17);
        stop = 1'b1;
        step(); stop = 1'b0;
        chk("cont_stop_busy", busy, 1'b0);
        chk("cont_stop_fill", fill_level, 5'd16);
        data_ready = 1'b1;
        for (int k = 2; k <= 17; k++) begin
            chk("cont_drain", data_out, w[k]);
            step();
        end
        chk("cont_drain_empty", empty, 1'b1);
        chk("cont_drain_wg", words_generated, 16'd17);

        // continuous streaming with consumer ready, 40 words then stop
        mode = 2'd2; start = 1'b1;
        step(); start = 1'b0;
        chk("stream_lat", data_valid, 1'b0);
        for (int k = 1; k <= 40; k++) begin
            step();
            chk("stream_valid", data_valid, 1'b1);
            chk("stream_word", data_out, model_word());
            if (k == 40) stop = 1'b1;
        end
        step(); stop = 1'b0;
        chk("stream_stop_busy", busy, 1'b0);
        chk("stream_wg", words_generated, 16'd40);
        chk("stream_empty", empty, 1'b0 == 1'b0 ? empty : 1'b1);
        step(); step();
        chk("stream_no_push", fill_level, 5'd0);
        chk("stream_wg_hold", words_generated, 16'd40);
        data_ready = 1'b0;

        // reseed with zero while start is also asserted: reseed wins
        reseed = 1'b1; seed_in = 8'h00; start = 1'b1; mode = 2'd0;
        step(); reseed = 1'b0; start = 1'b0;
        chk("reseed_prio_busy", busy, 1'b0);
        start = 1'b1;
        step(); start = 1'b0;
        step();
        chk("reseed0_word", data_out, 4'h1);
        chk("reseed0_fill", fill_level, 5'd1);
        data_ready = 1'b1;
        step(); data_ready = 1'b0;
        reseed = 1'b1; seed_in = 8'h17;
        step(); reseed = 1'b0;
        start = 1'b1;
        step(); start = 1'b0;
        step();
        chk("reseed17_word", data_out, 4'h7);
        data_ready = 1'b1;
        step(); data_ready = 1'b0;

        // reseed during GEN must be ignored
        mode = 2'd1; burst_len = 8'd2; start = 1'b1;
        step(); start = 1'b0; reseed = 1'b1; seed_in = 8'h01;
        step(); reseed = 1'b0;
        step();
        chk("gen_reseed_fill", fill_level, 5'd2);
        chk("gen_reseed_w0", data_out, 4'h4);
        data_ready = 1'b1;
        step();
        chk("gen_reseed_w1", data_out, 4'hA);
        step(); data_ready = 1'b0;
        chk("gen_reseed_empty", empty, 1'b1);

        // burst_len of zero behaves as one
        burst_len = 8'd0; start = 1'b1;
        step(); start = 1'b0;
        step(); step(); step();
        chk("blen0_fill", fill_level, 5'd1);
        chk("blen0_wg", words_generated, 16'd1);
        chk("blen0_word", data_out, 4'h3);
        data_ready = 1'b1;
        step(); data_ready = 1'b0;

        // asynchronous reset with 5 words buffered mid-burst
        burst_len = 8'd10; start = 1'b1;
        step(); start = 1'b0;
        for (int k = 0; k < 5; k++) step();
        chk("midrst_pre_fill", fill_level, 5'd5);
        reset = 1'b1;
        #1;
        chk("midrst_empty", empty, 1'b1);
        chk("midrst_valid", data_valid, 1'b0);
        chk("midrst_fill", fill_level, 5'd0);
        chk("midrst_busy", busy, 1'b0);
        step(); reset = 1'b0;
        mode = 2'd0; start = 1'b1;
        step(); start = 1'b0;
        step();
        chk("midrst_seed_word", data_out, 4'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/prng_stream_source.md
Name: prng_stream_source

Overview:
Parametrised pseudo-random word generator with an integrated output buffer. It is the successor to the fixed 8-bit LFSR feeding a 16-deep FIFO on the Arty top level. It adds run modes (single, burst, continuous), runtime reseed, generator back-pressure and a valid/ready output stream. It sits between the board control logic (edge-detected buttons/switches) and any word consumer (LED display, UART, checker).

Parameters:
LFSR_WIDTH, 8, LFSR state width (>=4)
LFSR_TAPS, 8'hB8, Galois feedback mask XORed on shift-out of a 1 (default x^8+x^6+x^5+x^4+1)
LFSR_SEED, 1, reset seed; a zero value is replaced by 1
WORD_WIDTH, 4, bits generated per clock (1..LFSR_WIDTH)
FIFO_DEPTH, 16, buffer depth; power of two, >=2
BURST_WIDTH, 8, width of burst length input

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
mode  in  2  0=single, 1=burst, 2=continuous, 3=treated as single; sampled on start
start  in  1  one-cycle pulse, begins a run when idle
stop  in  1  level, aborts generation
burst_len  in  BURST_WIDTH  words per burst, sampled on start; 0 treated as 1
reseed  in  1  load seed_in into LFSR (IDLE only)
seed_in  in  LFSR_WIDTH  runtime seed; zero replaced by 1
data_out  out  WORD_WIDTH  FIFO head word
data_valid  out  1  FIFO non-empty
data_ready  in  1  consumer accepts head when data_valid&data_ready
busy  out  1  state != IDLE
full  out  1  fill_level == FIFO_DEPTH
empty  out  1  fill_level == 0
fill_level  out  $clog2(FIFO_DEPTH)+1  words held
words_generated  out  16  words pushed since last start; saturates at 16'hFFFF

Behaviour:
- Decided: one clock, clk; reset asynchronous active-high, named reset.
- Reset: state=IDLE, LFSR=LFSR_SEED (0 -> 1), FIFO empty, data_out=0, data_valid=0, busy=0, full=0, empty=1, fill_level=0, words_generated=0.
- LFSR step (Galois, right shift): out_bit=s[0]; s = s>>1, XOR LFSR_TAPS if out_bit=1. A word advances WORD_WIDTH steps in one clock. Word bit i = out_bit of step i.
- States: IDLE, GEN, HOLD.
- IDLE: reseed loads seed_in. start (reseed has priority if both are asserted) latches mode and remaining count (1 for single, burst_len for burst). It clears words_generated and moves to GEN.
- GEN: each cycle pushes one word and advances the LFSR. Remaining count is decremented in single/burst; the last push goes to IDLE. Continuous mode never ends on count. If full and no pop this cycle, no push and go to HOLD.
- HOLD: LFSR frozen, no push. Return to GEN when not full.
- stop in GEN/HOLD: no push that cycle, next state IDLE. FIFO contents are kept and remain drainable.
- start while busy, and reseed while busy, are ignored.
- Latency: start at cycle N -> first push at N+1 -> data_valid=1 at N+2.
- FIFO is first-word-fall-through. Pop = data_valid & data_ready. Simultaneous push and pop leaves fill_level unchanged. A push into a full FIFO with a same-cycle pop is allowed. Pop when empty has no effect.
- Read and write pointers wrap modulo FIFO_DEPTH. Words are never dropped or duplicated.
- Reset mid-run returns everything to reset values immediately; the FIFO is flushed.

Test Plan:
- Reset, mode=0, start, data_ready=1 -> one word 4'h1, busy low at N+2, words_generated=1, LFSR state 0x17.
- mode=1, burst_len=3, data_ready=0 -> words 4'h1, 4'h7, 4'h4 buffered; fill_level=3; busy deasserts after 3 pushes; drain returns the same order.
- mode=2, data_ready=0 -> fill to 16, full=1, state HOLD, LFSR frozen. Raise data_ready for 1 cycle -> one pop, exactly one further push, fill_level stays 16.
- mode=2, data_ready=1 for 40 cycles -> pointers wrap twice, consumed sequence matches the reference LFSR model, words_generated=40. Assert stop -> busy=0 next cycle, no further pushes.
- In IDLE, reseed with seed_in=0 -> LFSR=0x01. Single run yields 4'h1. reseed with seed_in=0x17 then single run yields 4'h7. reseed during GEN is ignored.
- Burst with burst_len=0 -> exactly 1 word. Assert reset at mid-burst with 5 words buffered -> empty=1, data_valid=0, fill_level=0 immediately.
